fp_div: RTL and testbench



---
 rtl/fp_div.sv | 118 +++++++++++
 tb/tb_fp_div.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// fp_div: free-running 28-cycle binary32 divider (LOAD, 26x ITER, ROUND); define FP_DIV_FTZ_EN to flush subnormals to zero
module fp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        round_mode,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient
);
    typedef enum logic [1:0] {LOAD, ITER, ROUND} state_t;
    state_t state;
    logic [4:0] cnt;
    logic [25:0] rem, q, diff;
    logic [31:0] a_r, b_r, res;
    logic [1:0] op_r;
    logic rm_r;
    logic signed [9:0] ea, eb, e;
    logic [23:0] mb;
    logic [33:0] ul, ur;
    logic [2:0] ca, cb;
    logic sign, st, inc, ovf, uf;
    logic [24:0] ext;
    logic [32:0] base, sum;
`ifndef FP_DIV_FTZ_EN
    logic [7:0] sh;
`endif

    // {signed exponent, normalised 1.f mantissa}; subnormals are left-aligned by leading-zero count
    function automatic logic [33:0] unpack(input logic [31:0] x);
        logic [23:0] m;
        logic [4:0] s;
        m = {x[30:23] != 8'd0, x[22:0]};
        s = 5'd0;
`ifndef FP_DIV_FTZ_EN
        for (int i = 0; i < 24; i++) if (m[i]) s = 5'(23 - i);
`endif
        return {(x[30:23] == 8'd0) ? 10'd1 - {5'd0, s} : {2'd0, x[30:23]}, m << s};
    endfunction

    // {nan, inf, zero}
    function automatic logic [2:0] classify(input logic [31:0] x);
`ifdef FP_DIV_FTZ_EN
        return {&x[30:23] & |x[22:0], &x[30:23] & ~|x[22:0], ~|x[30:23]};
`else
        return {&x[30:23] & |x[22:0], &x[30:23] & ~|x[22:0], ~|x[30:0]};
`endif
    endfunction

    assign ul = unpack(dividend);
    assign ur = unpack(divisor);
    assign ca = classify(a_r);
    assign cb = classify(b_r);
    assign diff = rem - {2'd0, mb};

    // normalise, denormalise, round, pack and resolve special operands for the ROUND edge
    always_comb begin
        sign = a_r[31] ^ b_r[31];
        e = ea - eb + 10'sd127 - (q[25] ? 10'sd0 : 10'sd1);
        ext = q[25] ? q[25:1] : q[24:0];
        st = (q[25] & q[0]) | (|rem);
`ifndef FP_DIV_FTZ_EN
        sh = (e > 10'sd0) ? 8'd0 : (e < -10'sd24) ? 8'd26 : 8'(10'sd1 - e);
        st = st | (|(ext & ~(25'h1ffffff << sh)));
        ext = ext >> sh;
        uf = 1'b0;
`else
        uf = (e <= 10'sd0);
`endif
        inc = ~rm_r & ext[0] & (st | ext[1]);
        base = (e > 10'sd0) ? {e, ext[23:1]} : {9'd0, ext[24:1]};
        sum = base + {32'd0, inc};
        ovf = $signed(sum[32:23]) >= 10'sd255;
        res = (op_r != 2'b00 || ca[2] || cb[2] || (ca[0] && cb[0]) || (ca[1] && cb[1])) ? 32'h7fc00000 :
              (ca[1] || cb[0]) ? {sign, 8'hff, 23'd0} :
              (ca[0] || cb[1] || uf) ? {sign, 31'd0} :
              ovf ? (rm_r ? {sign, 31'h7f7fffff} : {sign, 8'hff, 23'd0}) :
              {sign, sum[30:0]};
    end

    // sequencer: capture operands, one restoring quotient bit per ITER edge, publish at ROUND
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            cnt <= 5'd0;
            rem <= 26'd0;
            q <= 26'd0;
            quotient <= 32'd0;
            a_r <= 32'd0;
            b_r <= 32'd0;
            op_r <= 2'd0;
            rm_r <= 1'b0;
            ea <= 10'sd0;
            eb <= 10'sd0;
            mb <= 24'd0;
        end else if (state == LOAD) begin
            a_r <= dividend;
            b_r <= divisor;
            op_r <= op;
            rm_r <= round_mode;
            ea <= ul[33:24];
            eb <= ur[33:24];
            mb <= ur[23:0];
            rem <= {2'd0, ul[23:0]};
            q <= 26'd0;
            cnt <= 5'd0;
            state <= ITER;
        end else if (state == ITER) begin
            rem <= (diff[25] ? rem : diff) << 1;
            q <= {q[24:0], ~diff[25]};
            cnt <= cnt + 5'd1;
            state <= (cnt == 5'd25) ? ROUND : ITER;
        end else begin
            quotient <= res;
            state <= LOAD;
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: random and directed checks of fp_div against an exact integer-division reference model
module tb_fp_div;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic round_mode = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] dividend = 32'd0, divisor = 32'd0, quotient;
    logic [31:0] held = 32'd0;
    int n_checks = 0, n_fail = 0;

    fp_div dut (
        .clk(clk),
        .reset(reset),
        .round_mode(round_mode),
        .op(op),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // exact quotient of integer significands, then rounded to binary32 from first principles
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic [1:0] o);
        logic s, an, bn, ai, bi, az, bz, g, stk;
        int ea, eb, p, bse, x, lsb, d, biased;
        longint unsigned ma, mb, qq, kept, low;
        s = a[31] ^ b[31];
        an = a[30:23] == 8'hff && a[22:0] != 23'd0;
        bn = b[30:23] == 8'hff && b[22:0] != 23'd0;
        ai = a[30:23] == 8'hff && a[22:0] == 23'd0;
        bi = b[30:23] == 8'hff && b[22:0] == 23'd0;
`ifdef FP_DIV_FTZ_EN
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
`else
        az = a[30:0] == 31'd0;
        bz = b[30:0] == 31'd0;
`endif
        if (o != 2'b00 || an || bn || (az && bz) || (ai && bi)) return 32'h7fc00000;
        if (ai || bz) return {s, 8'hff, 23'd0};
        if (az || bi) return {s, 31'd0};
        ma = {40'd0, a[30:23] != 8'd0, a[22:0]};
        mb = {40'd0, b[30:23] != 8'd0, b[22:0]};
        ea = (a[30:23] == 8'd0) ? -149 : int'(a[30:23]) - 150;
        eb = (b[30:23] == 8'd0) ? -149 : int'(b[30:23]) - 150;
        while (ma < 64'h800000) begin ma = ma << 1; ea--; end
        while (mb < 64'h800000) begin mb = mb << 1; eb--; end
        qq = (ma << 40) / mb;
        stk = ((ma << 40) % mb) != 64'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (qq[i]) p = i;
        bse = ea - eb - 40;
        x = p + bse;
`ifdef FP_DIV_FTZ_EN
        if (x + 127 <= 0) return {s, 31'd0};
`endif
        lsb = (x - 23 > -149) ? x - 23 : -149;
        d = lsb - bse;
        if (d > 64) begin
            kept = 64'd0;
            g = 1'b0;
            stk = 1'b1;
        end else begin
            g = qq[d-1];
            low = qq & ((64'd1 << (d - 1)) - 64'd1);
            stk = stk | (low != 64'd0);
            kept = (d == 64) ? 64'd0 : qq >> d;
        end
        if (!rm && g && (stk || kept[0])) kept++;
        if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; lsb++; end
        if (kept < (64'd1 << 23)) return {s, 8'd0, kept[22:0]};
        biased = lsb + 150;
        if (biased >= 255) return rm ? {s, 31'h7f7fffff} : {s, 8'hff, 23'd0};
        return {s, 8'(biased), kept[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: x[30:23] = 8'($urandom_range(110, 144));
            1: x[30:23] = 8'($urandom_range(0, 3));
            2: x[30:23] = 8'($urandom_range(250, 255));
            default: ;
        endcase
        return x;
    endfunction

    // call just before a LOAD edge; old result must hold through E26 and the new one appear at E27
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic [1:0] o,
                          input logic [31:0] expv, input string tag);
        int moved;
        dividend = a;
        divisor = b;
        round_mode = rm;
        op = o;
        moved = 0;
        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            if (quotient !== held) moved++;
            dividend = $urandom;
            divisor = $urandom;
            round_mode = 1'($urandom);
            op = 2'($urandom);
        end
        check({tag, " hold"}, 32'(moved), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " result"}, quotient, expv);
        held = expv;
    endtask

    initial begin
        logic [31:0] a, b;
        logic rm;
        logic [1:0] o;
        repeat (3) @(posedge clk);
        #1;
        check("reset", quotient, 32'd0);
        reset = 1'b0;
        do_div(32'h3f800000, 32'h3f800000, 1'b0, 2'b00, 32'h3f800000, "1/1 first");
        do_div(32'h40400000, 32'h40000000, 1'b0, 2'b00, 32'h3fc00000, "3/2");
        do_div(32'h3f800000, 32'h40400000, 1'b0, 2'b00, 32'h3eaaaaab, "1/3 rne");
        do_div(32'h3f800000, 32'h40400000, 1'b1, 2'b00, 32'h3eaaaaaa, "1/3 rz");
        do_div(32'h3f800000, 32'h00000000, 1'b0, 2'b00, 32'h7f800000, "1/0");
        do_div(32'h00000000, 32'h00000000, 1'b0, 2'b00, 32'h7fc00000, "0/0");
        do_div(32'h80000000, 32'h3f800000, 1'b0, 2'b00, 32'h80000000, "-0/1");
        do_div(32'h7f800000, 32'h7f800000, 1'b0, 2'b00, 32'h7fc00000, "inf/inf");
        do_div(32'h7fc01234, 32'h3f800000, 1'b0, 2'b00, 32'h7fc00000, "nan/1");
        do_div(32'h7f7fffff, 32'h3f000000, 1'b0, 2'b00, 32'h7f800000, "ovf rne");
        do_div(32'h7f7fffff, 32'h3f000000, 1'b1, 2'b00, 32'h7f7fffff, "ovf rz");
`ifdef FP_DIV_FTZ_EN
        do_div(32'h00800000, 32'h40000000, 1'b0, 2'b00, 32'h00000000, "unf");
        do_div(32'h00000001, 32'h00000001, 1'b0, 2'b00, 32'h7fc00000, "sub/sub");
`else
        do_div(32'h00800000, 32'h40000000, 1'b0, 2'b00, 32'h00400000, "unf");
        do_div(32'h00000001, 32'h00000001, 1'b0, 2'b00, 32'h3f800000, "sub/sub");
`endif
        do_div(32'h3f800000, 32'h3f800000, 1'b0, 2'b10, 32'h7fc00000, "reserved op");
        do_div(32'h3f800000, 32'h40400000, 1'b0, 2'b00, 32'h3eaaaaab, "b2b 1/3");
        do_div(32'hbf800000, 32'h40000000, 1'b0, 2'b00, 32'hbf000000, "b2b -1/2");
        dividend = 32'h40400000;
        divisor = 32'h40000000;
        round_mode = 1'b0;
        op = 2'b00;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset", quotient, 32'd0);
        reset = 1'b0;
        held = 32'd0;
        do_div(32'h40400000, 32'h40000000, 1'b0, 2'b00, 32'h3fc00000, "after reset");
        for (int i = 0; i < 200; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            rm = 1'($urandom);
            o = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_div(a, b, rm, o, ref_div(a, b, rm, o), $sformatf("rand %h/%h rm=%0d op=%0d", a, b, rm, o));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
